aer_event_encoder: RTL and testbench
====================================

# aer_event_encoder

Converts the one-hot grant pair from the two-level pixel arbitration tree (group grant and pixel-in-group grant) into an Address-Event Representation (AER) word. The word holds the 16×16 pixel coordinate and an optional capture timestamp, and is buffered in a small FIFO that is drained over a valid/ready interface. The block sits directly downstream of the level-1 group arbiter. It throttles that arbiter through `stall_o` and reports dropped or malformed events.

## Interface
- `FIFO_DEPTH`, default 8: number of FIFO entries; must be a power of two and ≥ 4.
- `TS_W`, default 16: timestamp width in bits.
- `clk`  input  1: clock.
- `reset`  input  1: reset, asynchronous, active-high.
- `evt_valid_i`  input  1: the arbiter presents a granted pixel this cycle.
- `grp_gnt_i`  input  16: one-hot group grant from the level-1 arbiter.
- `pix_gnt_i`  input  16: one-hot pixel grant from the granted group's round-robin.
- `stall_o`  output  1: the arbiter must deassert its enable while this is high.
- `aer_valid_o`  output  1: `aer_data_o` holds a valid event.
- `aer_ready_i`  input  1: the consumer accepts the word.
- `aer_data_o`  output  AER_W: event word. AER_W = 8 + TS_W with the timestamp enabled, 8 without.
- `drop_cnt_o`  output  8: saturating count of events dropped because the FIFO was full.
- `err_onehot_o`  output  1: sticky flag for a malformed grant.

## Operation
**Timestamp counter**
- Free-running `TS_W`-bit counter, 0 after reset.
- Increments every cycle and wraps from 2^TS_W−1 to 0.

**Capture stage (registered)**
- An event is captured on any edge where `evt_valid_i`=1.
- Group index g = position of the set bit in `grp_gnt_i`; pixel index p = position of the set bit in `pix_gnt_i`.
- Coordinates: x = (g mod 4)·4 + (p mod 4); y = (g div 4)·4 + (p div 4). Both are 4 bits wide with no overflow possible.
- Address byte = {y[3:0], x[3:0]}.
- The timestamp is the counter value in the cycle `evt_valid_i` is sampled.
- Word layout: address in `aer_data_o[AER_W-1 -: 8]`, timestamp in `[TS_W-1:0]`.

**Malformed grant**
- Occurs when `evt_valid_i`=1 and either grant vector is zero or has more than one bit set.
- The event is discarded and never reaches the FIFO.
- `err_onehot_o` is set and stays set until reset.

**FIFO write and drop**
- The capture register writes into the FIFO on the next edge.
- If the FIFO is full and no pop occurs in the same cycle, the event is dropped and `drop_cnt_o` increments, saturating at 255.
- Simultaneous push and pop while full: both succeed and the occupancy stays at `FIFO_DEPTH`.

**Output side**
- First-word-fall-through: `aer_valid_o` = FIFO not empty, and `aer_data_o` = head entry.
- A pop occurs on an edge where `aer_valid_o` and `aer_ready_i` are both 1.
- `aer_data_o` must stay stable while `aer_valid_o`=1 and `aer_ready_i`=0.

**Stall**
- `stall_o` = occupancy ≥ `FIFO_DEPTH`−2, registered.
- This covers the capture register in flight plus one cycle of arbiter reaction, so drops occur only if the arbiter ignores `stall_o`.

**Empty and wrap-around**
- Empty FIFO: `aer_valid_o`=0; `aer_data_o` holds its last value, don't-care.
- FIFO read and write pointers wrap modulo `FIFO_DEPTH`.

## Timing
- Reset values: `aer_valid_o`=0, `aer_data_o`=0, `stall_o`=0, `drop_cnt_o`=0, `err_onehot_o`=0; timestamp=0; FIFO empty; capture register invalid.
- Latency: event sampled at edge N → written to the FIFO at edge N+1 → `aer_valid_o`=1 after edge N+1, when the FIFO was empty.
- Throughput: one event per cycle sustained while `aer_ready_i`=1.
- `stall_o` asserts on the edge after occupancy reaches `FIFO_DEPTH`−2.
- Reset asserted mid-stream flushes all buffered events immediately and asynchronously; no partial word is emitted after reset releases.

## Configuration
- Macro: `AER_TIMESTAMP_EN`.
- Defined: the timestamp counter is present, AER_W = 8 + TS_W, and the word carries the capture time.
- Undefined: no counter is built, AER_W = 8, the word is the address byte only, and `TS_W` is ignored.
- Address, handshake, drop and error behaviour are identical in both builds.

## Structure
- Package `aer_pkg` holds:
  - `ADDR_W` = 8.
  - Packed typedef `aer_addr_t` = {y, x}, 4 bits each.
  - Grid constants GRP_DIM = 4 and PIX_DIM = 4.
  - Function `onehot16_to_idx` returning the index and a valid flag.
- Sub-module `aer_fifo`: synchronous first-word-fall-through FIFO parameterised by width and depth, exposing push, pop, full, empty and count.

## Test plan
- Grant `grp_gnt_i` bit 6 and `pix_gnt_i` bit 9 with the timestamp at 0x0012 and `aer_ready_i`=1 → `aer_valid_o` after edge N+1 with `aer_data_o` = 0x690012, or 0x69 without `AER_TIMESTAMP_EN`.
- Hold `aer_ready_i`=0 and push 8 events at `FIFO_DEPTH`=8:
  - `stall_o`=1 once 6 entries are buffered.
  - A 9th and 10th push give `drop_cnt_o`=2.
  - The first 8 words drain in order.
- `grp_gnt_i`=0x0003 with `evt_valid_i`=1 → no FIFO write and `err_onehot_o`=1, still set 100 cycles later.
- Full FIFO with a simultaneous push and pop → occupancy stays 8, `drop_cnt_o` unchanged, and the pushed word appears last.
- Drop 300 events → `drop_cnt_o`=255.
- Let the timestamp wrap from 0xFFFF to 0 between two events → captured values 0xFFFF and 0x0000.
- Assert `reset` with 5 entries queued → `aer_valid_o`=0 at once and every output returns to its reset value.

Source files
------------

// File: rtl/aer_pkg.sv
// Shared types and helpers for the AER event encoder.
// Build option AER_TIMESTAMP_EN appends a capture timestamp to every event word.
package aer_pkg;

    localparam int ADDR_W  = 8;
    localparam int GRP_DIM = 4;
    localparam int PIX_DIM = 4;

`ifdef AER_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] y;
        logic [3:0] x;
    } aer_addr_t;

    typedef struct packed {
        logic       vld;
        logic [3:0] idx;
    } oh_idx_t;

    // vld is set only when exactly one bit is high; idx is meaningful only then.
    function automatic oh_idx_t onehot16_to_idx(input logic [15:0] oh);
        oh_idx_t r;
        int      n;
        r = '0;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) begin
                r.idx = r.idx | 4'(i);
                n++;
            end
        end
        r.vld = (n == 1);
        return r;
    endfunction

endpackage

// File: rtl/aer_fifo.sv
// Synchronous first-word-fall-through FIFO; head entry is always visible on data_o.
// Storage is reset so the output word reads zero out of reset.
module aer_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [W-1:0]           data_i,
    input  logic                   pop_i,
    output logic [W-1:0]           data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign pop_ok  = pop_i && !empty_o;
    // A push into a full FIFO is accepted only if the head leaves on the same edge.
    assign push_ok = push_i && (!full_o || pop_ok);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok)
            count_d = count_q + (AW+1)'(1);
        else if (pop_ok && !push_ok)
            count_d = count_q - (AW+1)'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/aer_event_encoder.sv
// Turns a group/pixel one-hot grant pair into a buffered AER word with stall and drop reporting.
// Define AER_TIMESTAMP_EN to carry a TS_W-bit capture timestamp in the low bits of the word.
module aer_event_encoder
    import aer_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int TS_W       = 16,
    localparam int AER_W     = ADDR_W + (TS_EN ? TS_W : 0)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             evt_valid_i,
    input  logic [15:0]      grp_gnt_i,
    input  logic [15:0]      pix_gnt_i,
    output logic             stall_o,
    output logic             aer_valid_o,
    input  logic             aer_ready_i,
    output logic [AER_W-1:0] aer_data_o,
    output logic [7:0]       drop_cnt_o,
    output logic             err_onehot_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] STALL_LVL = CW'(FIFO_DEPTH - 2);

    oh_idx_t          grp, pix;
    aer_addr_t        addr;
    logic             evt_ok, evt_bad;
    logic [AER_W-1:0] cap_word;
    logic             cap_vld_q, cap_vld_d;
    logic [AER_W-1:0] cap_word_q, cap_word_d;
    logic [7:0]       drop_q, drop_d;
    logic             err_q, err_d, stall_q, stall_d;
    logic             fifo_full, fifo_empty, pop, drop;
    logic [CW-1:0]    fifo_cnt;

    assign grp     = onehot16_to_idx(grp_gnt_i);
    assign pix     = onehot16_to_idx(pix_gnt_i);
    assign evt_ok  = evt_valid_i && grp.vld && pix.vld;
    assign evt_bad = evt_valid_i && !(grp.vld && pix.vld);

    // Groups tile the 16x16 array as a 4x4 grid of 4x4 pixel blocks.
    always_comb begin
        addr   = '0;
        addr.x = (grp.idx % 4'(GRP_DIM)) * 4'(PIX_DIM) + (pix.idx % 4'(PIX_DIM));
        addr.y = (grp.idx / 4'(GRP_DIM)) * 4'(PIX_DIM) + (pix.idx / 4'(PIX_DIM));
    end

`ifdef AER_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ts_q <= '0;
        else       ts_q <= ts_q + TS_W'(1);
    end

    assign cap_word = {addr, ts_q};
`else
    assign cap_word = addr;
`endif

    assign pop  = aer_valid_o && aer_ready_i;
    assign drop = cap_vld_q && fifo_full && !pop;

    always_comb begin
        cap_vld_d  = evt_ok;
        cap_word_d = evt_ok ? cap_word : cap_word_q;
        err_d      = err_q | evt_bad;
        drop_d     = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
        stall_d    = (fifo_cnt >= STALL_LVL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_vld_q  <= 1'b0;
            cap_word_q <= '0;
            drop_q     <= '0;
            err_q      <= 1'b0;
            stall_q    <= 1'b0;
        end else begin
            cap_vld_q  <= cap_vld_d;
            cap_word_q <= cap_word_d;
            drop_q     <= drop_d;
            err_q      <= err_d;
            stall_q    <= stall_d;
        end
    end

    aer_fifo #(
        .W     (AER_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (cap_vld_q),
        .data_i  (cap_word_q),
        .pop_i   (pop),
        .data_o  (aer_data_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign aer_valid_o  = !fifo_empty;
    assign stall_o      = stall_q;
    assign drop_cnt_o   = drop_q;
    assign err_onehot_o = err_q;

endmodule

// File: tb/tb_aer_event_encoder.sv
// Randomized and directed bench for aer_event_encoder against a queue-based event model.
// Works in both builds; the timestamp wrap scenario runs only with AER_TIMESTAMP_EN.
module tb_aer_event_encoder;
    import aer_pkg::*;

    localparam int D     = 8;
    localparam int TS_W  = 16;
    localparam int AER_W = ADDR_W + (TS_EN ? TS_W : 0);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             evt_valid_i = 1'b0;
    logic             aer_ready_i = 1'b0;
    logic [15:0]      grp_gnt_i = '0;
    logic [15:0]      pix_gnt_i = '0;
    logic             stall_o, aer_valid_o, err_onehot_o;
    logic [AER_W-1:0] aer_data_o;
    logic [7:0]       drop_cnt_o;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: queue of expected words plus the one event in flight.
    logic [63:0] q[$];
    bit          pend_v;
    logic [63:0] pend_w;
    int          drop_m;
    bit          err_m, stall_m;
    longint      ts_m;
    logic [15:0] rg, rp;

    aer_event_encoder #(.FIFO_DEPTH(D), .TS_W(TS_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .evt_valid_i  (evt_valid_i),
        .grp_gnt_i    (grp_gnt_i),
        .pix_gnt_i    (pix_gnt_i),
        .stall_o      (stall_o),
        .aer_valid_o  (aer_valid_o),
        .aer_ready_i  (aer_ready_i),
        .aer_data_o   (aer_data_o),
        .drop_cnt_o   (drop_cnt_o),
        .err_onehot_o (err_onehot_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] exp_word(input logic [15:0] g, input logic [15:0] p,
                                             input longint ts);
        int     gi, pi;
        longint a;
        gi = 0;
        pi = 0;
        for (int i = 0; i < 16; i++) begin
            if (g[i]) gi = i;
            if (p[i]) pi = i;
        end
        a = ((gi / 4) * 4 + pi / 4) * 16 + (gi % 4) * 4 + pi % 4;
        return TS_EN ? 64'(a * (longint'(1) << TS_W) + ts) : 64'(a);
    endfunction

    function automatic logic [15:0] rand_oh();
        logic [15:0] v;
        v = 16'h0001;
        return v << $urandom_range(15, 0);
    endfunction

    function automatic logic [15:0] rand_bad();
        logic [15:0] v;
        do v = 16'($urandom); while ($countones(v) == 1);
        return v;
    endfunction

    task automatic model_edge(input logic ev, input logic [15:0] g, input logic [15:0] p,
                              input logic rdy);
        int occ;
        bit pop;
        occ = q.size();
        pop = (occ != 0) && rdy;
        if (pop) void'(q.pop_front());
        if (pend_v) begin
            if (occ == D && !pop) begin
                if (drop_m < 255) drop_m++;
            end else begin
                q.push_back(pend_w);
            end
        end
        stall_m = (occ >= D - 2);
        pend_v  = 1'b0;
        if (ev) begin
            if ($countones(g) == 1 && $countones(p) == 1) begin
                pend_v = 1'b1;
                pend_w = exp_word(g, p, ts_m);
            end else begin
                err_m = 1'b1;
            end
        end
        ts_m = (ts_m + 1) % (longint'(1) << TS_W);
    endtask

    task automatic check_outputs();
        chk("valid", 64'(aer_valid_o), 64'(q.size() != 0));
        if (q.size() != 0) chk("data", 64'(aer_data_o), q[0]);
        chk("stall", 64'(stall_o), 64'(stall_m));
        chk("drop", 64'(drop_cnt_o), 64'(drop_m));
        chk("err", 64'(err_onehot_o), 64'(err_m));
    endtask

    task automatic step(input logic ev, input logic [15:0] g, input logic [15:0] p,
                        input logic rdy);
        evt_valid_i = ev;
        grp_gnt_i   = g;
        pix_gnt_i   = p;
        aer_ready_i = rdy;
        @(posedge clk);
        model_edge(ev, g, p, rdy);
        #1;
        check_outputs();
    endtask

    task automatic apply_reset();
        #2 reset = 1'b1;
        evt_valid_i = 1'b0;
        grp_gnt_i   = '0;
        pix_gnt_i   = '0;
        aer_ready_i = 1'b0;
        #1;
        chk("rst_valid", 64'(aer_valid_o), 64'd0);
        chk("rst_data", 64'(aer_data_o), 64'd0);
        chk("rst_stall", 64'(stall_o), 64'd0);
        chk("rst_drop", 64'(drop_cnt_o), 64'd0);
        chk("rst_err", 64'(err_onehot_o), 64'd0);
        q.delete();
        pend_v  = 1'b0;
        drop_m  = 0;
        err_m   = 1'b0;
        stall_m = 1'b0;
        ts_m    = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
    endtask

    initial begin
        apply_reset();

        // Group 6 / pixel 9 captured at timestamp 0x12 -> address 0x69.
        while (ts_m != 18) step(1'b0, '0, '0, 1'b1);
        step(1'b1, 16'h0040, 16'h0200, 1'b1);
        step(1'b0, '0, '0, 1'b1);
        chk("t1_valid", 64'(aer_valid_o), 64'd1);
        chk("t1_data", 64'(aer_data_o), TS_EN ? 64'h690012 : 64'h69);
        repeat (2) step(1'b0, '0, '0, 1'b1);

        // Ten events into a blocked consumer: eight buffered, two dropped.
        for (int i = 0; i < 10; i++) step(1'b1, rand_oh(), rand_oh(), 1'b0);
        step(1'b0, '0, '0, 1'b0);
        chk("fill_drop", 64'(drop_cnt_o), 64'd2);
        chk("fill_stall", 64'(stall_o), 64'd1);
        repeat (10) step(1'b0, '0, '0, 1'b1);
        chk("drain_empty", 64'(aer_valid_o), 64'd0);

        // Malformed grant: discarded, sticky error.
        step(1'b1, 16'h0003, 16'h0001, 1'b1);
        repeat (100) step(1'b0, '0, '0, 1'b1);
        chk("err_sticky", 64'(err_onehot_o), 64'd1);
        chk("err_nowrite", 64'(aer_valid_o), 64'd0);

        // Push and pop on the same edge while full.
        for (int i = 0; i < 8; i++) step(1'b1, rand_oh(), rand_oh(), 1'b0);
        step(1'b1, 16'h8000, 16'h8000, 1'b0);
        step(1'b0, '0, '0, 1'b1);
        chk("pp_drop", 64'(drop_cnt_o), 64'd2);
        repeat (7) step(1'b0, '0, '0, 1'b1);
        chk("pp_last_valid", 64'(aer_valid_o), 64'd1);
        chk("pp_last_addr", 64'(aer_data_o) >> (AER_W - 8), 64'hFF);
        repeat (2) step(1'b0, '0, '0, 1'b1);

        // Saturating drop counter.
        for (int i = 0; i < 308; i++) step(1'b1, rand_oh(), rand_oh(), 1'b0);
        step(1'b0, '0, '0, 1'b0);
        chk("drop_sat", 64'(drop_cnt_o), 64'd255);
        repeat (9) step(1'b0, '0, '0, 1'b1);

        // Asynchronous reset with five entries queued.
        for (int i = 0; i < 5; i++) step(1'b1, rand_oh(), rand_oh(), 1'b0);
        step(1'b0, '0, '0, 1'b0);
        chk("pre_rst_valid", 64'(aer_valid_o), 64'd1);
        apply_reset();
        step(1'b0, '0, '0, 1'b1);
        chk("post_rst_valid", 64'(aer_valid_o), 64'd0);

        // Random traffic with occasional malformed grants and back-pressure.
        for (int i = 0; i < 600; i++) begin
            rg = rand_oh();
            rp = rand_oh();
            if ($urandom_range(29, 0) == 0) rg = rand_bad();
            step($urandom_range(9, 0) < 6, rg, rp, $urandom_range(1, 0) == 1);
        end
        repeat (12) step(1'b0, '0, '0, 1'b1);

`ifdef AER_TIMESTAMP_EN
        apply_reset();
        while (ts_m != (longint'(1) << TS_W) - 1) step(1'b0, '0, '0, 1'b1);
        step(1'b1, 16'h0001, 16'h0001, 1'b0);
        step(1'b1, 16'h0002, 16'h0004, 1'b0);
        step(1'b0, '0, '0, 1'b0);
        chk("wrap_ts_last", 64'(aer_data_o) & ((64'd1 << TS_W) - 1), (64'd1 << TS_W) - 1);
        step(1'b0, '0, '0, 1'b1);
        chk("wrap_ts_zero", 64'(aer_data_o) & ((64'd1 << TS_W) - 1), 64'd0);
        step(1'b0, '0, '0, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
